alu_control_secuencial: RTL and testbench
=========================================

// Module: alu_control_secuencial
// PURPOSE
// - Parametrised ALU operand/opcode loader.
// - Debounces and edge-detects the board buttons; a held button acts as exactly one press.
// - Loads operand A, operand B and the opcode from the switches.
// - On an explicit execute press, waits a configurable ALU latency and registers the external ALU result.
// - Sits between board I/O (switches, buttons, leds) and the alu instance, which stays external.
// PARAMETERS
// BUS_DATOS        4  width of i_switches, of each operand and of the alu operand ports
// BUS_SALIDA       4  width of i_resultado and of o_leds
// CANT_BIT_OPCODE  4  opcode width; must be <= BUS_DATOS
// CANT_BOTONES     4  button count; fixed at 4 ([0]=A, [1]=B, [2]=opcode, [3]=execute)
// DEBOUNCE_CYCLES  1000000  consecutive equal synchronised samples needed to accept a level; must be >= 1
// ALU_LATENCY      1  cycles from operands stable to i_resultado valid; must be >= 1
// PORTS
// i_clock      in   1                clock; all logic on its rising edge
// i_reset      in   1                synchronous, active-high reset
// i_switches   in   BUS_DATOS        data / opcode source
// i_botones    in   CANT_BOTONES     raw asynchronous buttons, active high
// i_resultado  in   BUS_SALIDA       result from the external alu
// o_operando_1 out  BUS_DATOS        registered operand A, to the alu
// o_operando_2 out  BUS_DATOS        registered operand B, to the alu
// o_opcode     out  CANT_BIT_OPCODE  registered opcode, to the alu
// o_leds       out  BUS_SALIDA       last latched result
// o_busy       out  1                high while the FSM is in EXEC
// o_valid      out  1                one-cycle pulse when o_leds is updated
// o_error      out  1                one-cycle pulse when more than one press occurs in the same cycle
// BEHAVIOUR
// - Reset (sync, active high):
//   - All outputs, FSM (IDLE), synchronisers, debounce counters and debounced states go to 0.
//   - A button still held when reset deasserts is seen as a fresh press after the debounce time.
// - Per button k:
//   - 2-FF synchroniser feeds a counter.
//   - Counter clears whenever the synchronised sample equals the debounced state.
//   - When the counter reaches DEBOUNCE_CYCLES, debounced state <= sample and counter <= 0.
//   - press[k] = debounced rising edge, high for exactly 1 cycle; falling edges produce nothing.
// - Latency: input rise to register update = DEBOUNCE_CYCLES+3 rising edges.
// - Glitches shorter than DEBOUNCE_CYCLES are ignored.
// - Arbitration:
//   - Act only if exactly one press[k] is high (one-hot).
//   - If more than one is high, no register changes and o_error pulses for 1 cycle.
// - FSM states: IDLE, EXEC, DONE.
// - IDLE:
//   - press[0] -> o_operando_1 <= i_switches.
//   - press[1] -> o_operando_2 <= i_switches.
//   - press[2] -> o_opcode <= i_switches[CANT_BIT_OPCODE-1:0].
//   - press[3] -> EXEC, latency counter <= 0.
// - EXEC:
//   - o_busy = 1; operands and opcode are frozen, and all presses (including execute) are dropped.
//   - A multi-press still pulses o_error.
//   - Counter increments each cycle; when it reaches ALU_LATENCY-1 -> DONE.
// - DONE (1 cycle): o_leds <= i_resultado, o_valid = 1, o_busy = 0, -> IDLE.
// - Load to execute: a load press and an execute press can never coincide (one-hot rule), so an execute always uses operands already registered.
// - Reset during EXEC or DONE: immediate return to IDLE; no o_valid; o_leds = 0.
// - Width rules: no arithmetic on operands here. o_leds is a plain copy of i_resultado; no extension or truncation.
// STRUCTURE
// - Package alu_pkg: FSM state localparams (IDLE=2'd0, EXEC=2'd1, DONE=2'd2), button indices (BTN_A=0, BTN_B=1, BTN_OP=2, BTN_EXEC=3), default widths.
// - Sub-module boton_debounce: one button, with synchroniser, counter, debounced state and press pulse; parameter DEBOUNCE_CYCLES.
// - Instantiate boton_debounce CANT_BOTONES times via generate.
// - Top level holds the arbitration, operand registers, FSM and latency counter.
// TESTING
// - Bench uses DEBOUNCE_CYCLES=4, ALU_LATENCY=2 and a model alu with i_resultado = A+B when opcode = 4'b0000.
// - Reset: hold i_reset 3 cycles with random inputs -> every output 0, o_busy=0.
// - Single load: i_switches=4'h5, i_botones=4'b0001 held 20 cycles.
//   -> o_operando_1=4'h5 at edge 7 after the rise.
//   -> No further change while held; re-press with 4'h9 -> 4'h9.
// - Glitch: i_botones[1] high 3 cycles, i_switches=4'hA -> o_operando_2 unchanged (0).
// - Simultaneous: i_botones=4'b0011 held -> o_error one 1-cycle pulse; o_operando_1/2 unchanged.
// - Execute: load A=3, B=2, op=0, then press button 3.
//   -> o_busy high 2 cycles, then o_leds=4'h5 with a 1-cycle o_valid.
//   -> A press of button 0 during EXEC leaves A=3.
// - Reset mid-op: assert i_reset while o_busy=1 -> next cycle IDLE, o_leds=0, no o_valid pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand/opcode loader: FSM encoding, button
// indices and default widths.
package alu_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StExec = EXEC,
        StDone = DONE
    } alu_state_e;

    localparam int unsigned BTN_A    = 0;
    localparam int unsigned BTN_B    = 1;
    localparam int unsigned BTN_OP   = 2;
    localparam int unsigned BTN_EXEC = 3;

    localparam int unsigned DEF_BUS_DATOS       = 4;
    localparam int unsigned DEF_BUS_SALIDA      = 4;
    localparam int unsigned DEF_CANT_BIT_OPCODE = 4;
    localparam int unsigned DEF_CANT_BOTONES    = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEF_ALU_LATENCY     = 1;

endpackage

// File: rtl/boton_debounce.sv
// One board button: 2-FF synchroniser, debounce counter, debounced level and a
// single-cycle pulse on each accepted rising edge.
module boton_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_boton,
    output logic o_press
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            estado_q;
    logic            estado_d;
    logic            previo_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // The level is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        if (sync2_q == estado_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            estado_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            estado_q <= 1'b0;
            previo_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= i_boton;
            sync2_q  <= sync1_q;
            estado_q <= estado_d;
            previo_q <= estado_q;
            cnt_q    <= cnt_d;
        end
    end

    assign o_press = estado_q & ~previo_q;

endmodule

// File: rtl/alu_control_secuencial.sv
// Loads ALU operands and opcode from the switches on debounced button presses and
// latches the external ALU result a fixed latency after an execute press.
module alu_control_secuencial
    import alu_pkg::*;
#(
    parameter int unsigned BUS_DATOS       = DEF_BUS_DATOS,
    parameter int unsigned BUS_SALIDA      = DEF_BUS_SALIDA,
    parameter int unsigned CANT_BIT_OPCODE = DEF_CANT_BIT_OPCODE,
    parameter int unsigned CANT_BOTONES    = DEF_CANT_BOTONES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned ALU_LATENCY     = DEF_ALU_LATENCY
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [BUS_DATOS-1:0]       i_switches,
    input  logic [CANT_BOTONES-1:0]    i_botones,
    input  logic [BUS_SALIDA-1:0]      i_resultado,
    output logic [BUS_DATOS-1:0]       o_operando_1,
    output logic [BUS_DATOS-1:0]       o_operando_2,
    output logic [CANT_BIT_OPCODE-1:0] o_opcode,
    output logic [BUS_SALIDA-1:0]      o_leds,
    output logic                       o_busy,
    output logic                       o_valid,
    output logic                       o_error
);

    localparam int unsigned LatW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [LatW-1:0] LatLast = LatW'(ALU_LATENCY - 1);

    logic [CANT_BOTONES-1:0] press;
    logic                    single;
    logic                    multi;

    for (genvar k = 0; k < CANT_BOTONES; k++) begin : g_boton
        boton_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_boton (
            .i_clock(i_clock),
            .i_reset(i_reset),
            .i_boton(i_botones[k]),
            .o_press(press[k])
        );
    end

    assign single = $onehot(press);
    assign multi  = (press != '0) && !single;

    alu_state_e                 state_q, state_d;
    logic [LatW-1:0]            lat_q, lat_d;
    logic [BUS_DATOS-1:0]       op1_q, op1_d;
    logic [BUS_DATOS-1:0]       op2_q, op2_d;
    logic [CANT_BIT_OPCODE-1:0] opc_q, opc_d;
    logic [BUS_SALIDA-1:0]      leds_q, leds_d;
    logic                       valid_q, valid_d;
    logic                       error_q, error_d;

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        opc_d   = opc_q;
        leds_d  = leds_q;
        valid_d = 1'b0;
        error_d = multi;
        unique case (state_q)
            StIdle: begin
                if (single) begin
                    if (press[BTN_A]) op1_d = i_switches;
                    if (press[BTN_B]) op2_d = i_switches;
                    if (press[BTN_OP]) opc_d = i_switches[CANT_BIT_OPCODE-1:0];
                    if (press[BTN_EXEC]) begin
                        state_d = StExec;
                        lat_d   = '0;
                    end
                end
            end
            // Operands stay frozen here; every press is dropped.
            StExec: begin
                if (lat_q == LatLast) begin
                    state_d = StDone;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            StDone: begin
                leds_d  = i_resultado;
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= StIdle;
            lat_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            opc_q   <= '0;
            leds_q  <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            opc_q   <= opc_d;
            leds_q  <= leds_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign o_operando_1 = op1_q;
    assign o_operando_2 = op2_q;
    assign o_opcode     = opc_q;
    assign o_leds       = leds_q;
    assign o_busy       = (state_q == StExec);
    assign o_valid      = valid_q;
    assign o_error      = error_q;

endmodule

// File: tb/tb_alu_control_secuencial.sv
// Bench for alu_control_secuencial with a small adder/xor ALU model and a queue
// of expected results popped on each o_valid pulse.
module tb_alu_control_secuencial;

    localparam int unsigned BD  = 4;
    localparam int unsigned BS  = 4;
    localparam int unsigned OPW = 4;
    localparam int unsigned NB  = 4;
    localparam int unsigned DEB = 4;
    localparam int unsigned LAT = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [BD-1:0]  sw  = '0;
    logic [NB-1:0]  btn = '0;
    logic [BS-1:0]  res;
    logic [BD-1:0]  op1;
    logic [BD-1:0]  op2;
    logic [OPW-1:0] opc;
    logic [BS-1:0]  leds;
    logic           busy;
    logic           valid;
    logic           err;

    logic           use_rand = 1'b1;
    logic [BS-1:0]  rand_res = '0;
    logic [BS-1:0]  exp_q[$];
    int             total = 0;
    int             bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        if (use_rand) res = rand_res;
        else if (opc == '0) res = op1 + op2;
        else res = op1 ^ op2;
    end

    alu_control_secuencial #(
        .BUS_DATOS(BD),
        .BUS_SALIDA(BS),
        .CANT_BIT_OPCODE(OPW),
        .CANT_BOTONES(NB),
        .DEBOUNCE_CYCLES(DEB),
        .ALU_LATENCY(LAT)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_switches(sw),
        .i_botones(btn),
        .i_resultado(res),
        .o_operando_1(op1),
        .o_operando_2(op2),
        .o_opcode(opc),
        .o_leds(leds),
        .o_busy(busy),
        .o_valid(valid),
        .o_error(err)
    );

    task automatic wait_edges(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NB-1:0] b, input logic [BD-1:0] s);
        @(posedge clk);
        #1;
        btn = b;
        sw  = s;
    endtask

    task automatic load_value(input logic [NB-1:0] b, input logic [BD-1:0] s);
        drive(b, s);
        wait_edges(10);
        btn = '0;
        wait_edges(12);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        use_rand = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            sw       = BD'($urandom);
            btn      = NB'($urandom);
            rand_res = BS'($urandom);
        end
        @(negedge clk);
        total++; if (op1 !== '0) begin bad++; $display("FAIL reset_op1 got=%h want=0", op1); end
        total++; if (op2 !== '0) begin bad++; $display("FAIL reset_op2 got=%h want=0", op2); end
        total++; if (opc !== '0) begin bad++; $display("FAIL reset_opc got=%h want=0", opc); end
        total++; if (leds !== '0) begin bad++; $display("FAIL reset_leds got=%h want=0", leds); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", err); end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        btn      = '0;
        sw       = '0;
        use_rand = 1'b0;
        wait_edges(10);
    endtask

    task automatic test_single_load();
        logic [BD-1:0] want;
        drive(4'b0001, 4'h5);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            want = (n < 7) ? 4'h0 : 4'h5;
            total++;
            if (op1 !== want) begin
                bad++;
                $display("FAIL load_edge%0d got=%h want=%h", n, op1, want);
            end
            if (n == 8) sw = 4'h9;
        end
        @(posedge clk);
        #1;
        btn = '0;
        wait_edges(12);
        drive(4'b0001, 4'h9);
        wait_edges(10);
        total++; if (op1 !== 4'h9) begin bad++; $display("FAIL repress got=%h want=9", op1); end
        btn = '0;
        wait_edges(12);
    endtask

    task automatic test_glitch();
        drive(4'b0010, 4'hA);
        wait_edges(3);
        btn = '0;
        wait_edges(15);
        total++; if (op2 !== 4'h0) begin bad++; $display("FAIL glitch_op2 got=%h want=0", op2); end
    endtask

    task automatic test_simultaneous();
        int err_n = 0;
        drive(4'b0011, 4'h7);
        for (int n = 1; n <= 15; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (err) err_n++;
        end
        @(posedge clk);
        #1;
        btn = '0;
        wait_edges(12);
        total++; if (err_n != 1) begin bad++; $display("FAIL multi_error_pulses got=%0d want=1", err_n); end
        total++; if (op1 !== 4'h9) begin bad++; $display("FAIL multi_op1 got=%h want=9", op1); end
        total++; if (op2 !== 4'h0) begin bad++; $display("FAIL multi_op2 got=%h want=0", op2); end
    endtask

    task automatic test_execute();
        int busy_n = 0;
        int first_busy = -1;
        int valid_n = 0;
        int valid_at = -1;
        logic [BS-1:0] want;
        load_value(4'b0001, 4'h3);
        load_value(4'b0010, 4'h2);
        load_value(4'b0100, 4'h0);
        total++; if (op1 !== 4'h3) begin bad++; $display("FAIL exec_load_a got=%h want=3", op1); end
        total++; if (op2 !== 4'h2) begin bad++; $display("FAIL exec_load_b got=%h want=2", op2); end
        total++; if (opc !== 4'h0) begin bad++; $display("FAIL exec_load_op got=%h want=0", opc); end
        drive(4'b1000, 4'h0);
        exp_q.push_back(4'h5);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            if (n == 1) begin
                #1;
                btn = 4'b1001;
                sw  = 4'hF;
            end
            @(negedge clk);
            if (busy) begin
                busy_n++;
                if (first_busy < 0) first_busy = n;
            end
            if (valid) begin
                valid_n++;
                valid_at = n;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL exec_unexpected_valid got=%h want=none", leds);
                end else begin
                    want = exp_q.pop_front();
                    if (leds !== want) begin
                        bad++;
                        $display("FAIL exec_leds got=%h want=%h", leds, want);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        btn = '0;
        wait_edges(12);
        total++; if (busy_n != 2) begin bad++; $display("FAIL exec_busy_cycles got=%0d want=2", busy_n); end
        total++; if (first_busy != 7) begin bad++; $display("FAIL exec_busy_start got=%0d want=7", first_busy); end
        total++; if (valid_n != 1) begin bad++; $display("FAIL exec_valid_pulses got=%0d want=1", valid_n); end
        total++; if (valid_at != 10) begin bad++; $display("FAIL exec_valid_edge got=%0d want=10", valid_at); end
        total++; if (op1 !== 4'h3) begin bad++; $display("FAIL exec_a_frozen got=%h want=3", op1); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL exec_queue_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_op();
        bit seen = 1'b0;
        int valid_n = 0;
        drive(4'b1000, 4'h0);
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL midop_busy_timeout got=0 want=1");
        end else begin
            rst = 1'b1;
            btn = '0;
            @(negedge clk);
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL midop_busy got=%b want=0", busy); end
            total++; if (leds !== '0) begin bad++; $display("FAIL midop_leds got=%h want=0", leds); end
            total++; if (valid !== 1'b0) begin bad++; $display("FAIL midop_valid got=%b want=0", valid); end
            total++; if (op1 !== '0) begin bad++; $display("FAIL midop_op1 got=%h want=0", op1); end
            rst = 1'b0;
            for (int n = 0; n < 12; n++) begin
                @(negedge clk);
                if (valid) valid_n++;
            end
            total++; if (valid_n != 0) begin bad++; $display("FAIL midop_late_valid got=%0d want=0", valid_n); end
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_glitch();
        test_simultaneous();
        test_execute();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
